// File: rtl/mips_run_monitor.sv
// rtl/mips_run_monitor.sv - MIPS run controller: cycle/retire counters, halt/stall/timeout stop, optional PC trace (MIPS_TRACE_EN)
// A one-cycle stop_req marks the end of a run; counters freeze until the next start.
module mips_run_monitor #(
    parameter int PC_W        = 32,
    parameter int CYCLE_W     = 32,
    parameter int MAX_CYCLES  = 1000,
    parameter int STALL_LIMIT = 8,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          start,
    input  logic [PC_W-1:0]               pc,
    input  logic                          pc_valid,
    input  logic                          halt_insn,
    output logic [CYCLE_W-1:0]            cycle_count,
    output logic [CYCLE_W-1:0]            instr_count,
    output logic [1:0]                    run_state,
    output logic                          done,
    output logic                          timed_out,
    output logic                          stop_req
`ifdef MIPS_TRACE_EN
    ,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [PC_W-1:0]               trace_pc
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        HALTED  = 2'b10,
        TIMEOUT = 2'b11
    } state_t;

    localparam int                 STALL_W    = $clog2(STALL_LIMIT + 1);
    localparam logic [CYCLE_W-1:0] LAST_CYCLE = CYCLE_W'(MAX_CYCLES - 1);

    if (STALL_LIMIT < 1 || TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_config
        $error("mips_run_monitor: STALL_LIMIT must be >= 1 and TRACE_DEPTH a power of 2 >= 2");
    end

    state_t             state;
    logic [STALL_W-1:0] stall_cnt;
    logic [PC_W-1:0]    last_pc;

    logic [CYCLE_W-1:0] cycle_next;
    logic [CYCLE_W-1:0] instr_next;
    logic [STALL_W-1:0] stall_next;
    logic               pc_same;
    logic               halt_hit;
    logic               stall_hit;
    logic               budget_hit;

    always_comb begin
        cycle_next = (&cycle_count) ? cycle_count : cycle_count + CYCLE_W'(1);
        instr_next = instr_count;
        if (pc_valid && !(&instr_count))
            instr_next = instr_count + CYCLE_W'(1);
        pc_same    = (pc == last_pc);
        stall_next = '0;
        if (pc_same)
            stall_next = (stall_cnt == STALL_W'(STALL_LIMIT)) ? stall_cnt : stall_cnt + STALL_W'(1);
        halt_hit   = pc_valid && halt_insn;
        // Halt fires on the edge that would bring the counter up to the limit.
        stall_hit  = pc_same && (stall_cnt == STALL_W'(STALL_LIMIT - 1));
        budget_hit = (MAX_CYCLES != 0) && (cycle_count == LAST_CYCLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            cycle_count <= '0;
            instr_count <= '0;
            stall_cnt   <= '0;
            last_pc     <= '0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
            stop_req    <= 1'b0;
        end else begin
            stop_req <= 1'b0;
            case (state)
                IDLE, HALTED, TIMEOUT: begin
                    if (start) begin
                        state       <= RUN;
                        cycle_count <= '0;
                        instr_count <= '0;
                        stall_cnt   <= '0;
                        last_pc     <= pc;
                        done        <= 1'b0;
                        timed_out   <= 1'b0;
                    end
                end
                RUN: begin
                    // The exit edge still counts this cycle and its retirement.
                    cycle_count <= cycle_next;
                    instr_count <= instr_next;
                    stall_cnt   <= stall_next;
                    last_pc     <= pc;
                    if (halt_hit || stall_hit) begin
                        state    <= HALTED;
                        done     <= 1'b1;
                        stop_req <= 1'b1;
                    end else if (budget_hit) begin
                        state     <= TIMEOUT;
                        done      <= 1'b1;
                        timed_out <= 1'b1;
                        stop_req  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign run_state = state;

`ifdef MIPS_TRACE_EN
    localparam int TRACE_AW = $clog2(TRACE_DEPTH);

    logic [PC_W-1:0]     trace_buf [TRACE_DEPTH];
    logic [TRACE_AW-1:0] wr_ptr;
    logic [TRACE_AW-1:0] rd_ptr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            for (int i = 0; i < TRACE_DEPTH; i++)
                trace_buf[i] <= '0;
        end else if (state == RUN && pc_valid) begin
            trace_buf[wr_ptr] <= pc;
            wr_ptr            <= wr_ptr + TRACE_AW'(1);
        end
    end

    // wr_ptr points one past the newest entry; index 0 reads the newest.
    assign rd_ptr   = wr_ptr - TRACE_AW'(1) - trace_idx;
    assign trace_pc = trace_buf[rd_ptr];
`endif

endmodule
